adder_sequencer: RTL and testbench

Multi-cycle controller that shares one external 4-bit ripple-adder datapath between two requesters. It performs `4*NIBBLES`-bit additions by streaming one nibble per cycle through the shared adder, LSB nibble first, and keeps the inter-nibble carry in a register. Round-robin arbitration decides which requester's operation runs. The result is returned over a valid/ready response channel tagged with the requester id.

---
 rtl/adder_sequencer.sv | 166 ++++++++++++++++
 tb/tb_adder_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_sequencer.sv
// Shares one external 4-bit adder between two requesters, streaming W-bit additions
// nibble by nibble (LSB first) with round-robin arbitration and a valid/ready response.
module adder_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req1_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    sum_r;
  logic            carry_r;
  logic            id_r;
  logic            last_grant_r;
  logic            grant_s;
  logic            grant_valid_s;
  logic            accept_s;
  logic            last_idx_s;

  assign accept_s   = (state_r == IDLE) && grant_valid_s;
  assign last_idx_s = (idx_r == IW'(NIBBLES - 1));

  // Round-robin arbiter: on a tie the requester not granted last time wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = ~last_grant_r;
    end else if (req1_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b1;
    end else if (req0_valid) begin
      grant_valid_s = 1'b1;
      grant_s       = 1'b0;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_idx_s) state_s = DONE;
        else            state_s = RUN;
      end
      DONE: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture at acceptance and per-nibble accumulation while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= '0;
      a_r          <= '0;
      b_r          <= '0;
      sum_r        <= '0;
      carry_r      <= 1'b0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r          <= grant_s ? req1_a : req0_a;
            b_r          <= grant_s ? req1_b : req0_b;
            carry_r      <= grant_s ? req1_cin : req0_cin;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            idx_r        <= '0;
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= add_sum;
          carry_r                    <= add_cout;
          idx_r                      <= last_idx_s ? '0 : idx_r + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the state register; everything idles at zero.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_sum    = '0;
    rsp_cout   = 1'b0;
    case (state_r)
      IDLE: begin
        req0_ready = grant_valid_s && !grant_s;
        req1_ready = grant_valid_s && grant_s;
      end
      RUN: begin
        add_a   = a_r[{idx_r, 2'b00} +: 4];
        add_b   = b_r[{idx_r, 2'b00} +: 4];
        add_cin = carry_r;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_r;
        rsp_sum   = sum_r;
        rsp_cout  = carry_r;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized self-checking bench for adder_sequencer (NIBBLES=4) with an attached
// behavioural 4-bit adder and an arithmetic reference model.
module tb_adder_sequencer;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [4:0]  nib_s;

  int   checks = 0;
  int   errors = 0;
  logic model_last;

  adder_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  assign nib_s = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum  = nib_s[3:0];
  assign add_cout = nib_s[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_sum"}, rsp_sum, 16'h0);
    check({tag, "_add_a"}, add_a, 4'h0);
    check({tag, "_add_cin"}, add_cin, 1'b0);
  endtask

  // Serve one operation from requester id, expected to win arbitration right now.
  task automatic serve(input logic id, input int stall, input bit keep);
    logic [15:0] a, b;
    logic        cin;
    logic [16:0] full;
    int          m, c;
    a    = id ? req1_a : req0_a;
    b    = id ? req1_b : req0_b;
    cin  = id ? req1_cin : req0_cin;
    full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    #1;
    check("accept_ready0", req0_ready, id == 1'b0);
    check("accept_ready1", req1_ready, id == 1'b1);
    check("idle_add_a", add_a, 4'h0);
    model_last = id;
    tick();
    if (!keep) begin
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      m = (1 << (4 * k)) - 1;
      c = ((int'(a) & m) + (int'(b) & m) + int'(cin)) >> (4 * k);
      #1;
      check("run_add_a", add_a, (a >> (4 * k)) & 16'hF);
      check("run_add_b", add_b, (b >> (4 * k)) & 16'hF);
      check("run_add_cin", add_cin, c[0]);
      check("run_rsp_valid", rsp_valid, 1'b0);
      check("run_ready", {req1_ready, req0_ready}, 2'b00);
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      #1;
      check("done_valid", rsp_valid, 1'b1);
      check("done_sum", rsp_sum, full[15:0]);
      check("done_cout", rsp_cout, full[16]);
      check("done_id", rsp_id, id);
      check("done_ready", {req1_ready, req0_ready}, 2'b00);
      check("done_add_a", add_a, 4'h0);
      tick();
    end
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_rsp_sum", rsp_sum, 16'h0);
  endtask

  initial begin
    logic v0, v1, exp_id;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = 16'h0; req0_b = 16'h0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0; req1_cin = 1'b0;
    model_last = 1'b1;
    #1;
    check_quiet("reset_async");
    check("reset_ready", {req1_ready, req0_ready}, 2'b00);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_quiet("after_reset");
    check("after_reset_ready", {req1_ready, req0_ready}, 2'b00);

    // Tie out of reset: req0 first, then req1.
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
    serve(1'b0, 0, 1'b0);
    serve(1'b1, 0, 1'b0);
    #1;
    check("tie_no_repeat", {req1_ready, req0_ready}, 2'b00);
    tick();

    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
    serve(1'b0, 0, 1'b0);
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0000; req0_cin = 1'b1;
    serve(1'b0, 0, 1'b0);
    req1_valid = 1'b1; req1_a = 16'hA5A5; req1_b = 16'h5A5B; req1_cin = 1'b1;
    serve(1'b1, 3, 1'b0);

    for (int i = 0; i < 25; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      req0_valid = v0; req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
      req1_valid = v1; req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      exp_id = (v0 && v1) ? ~model_last : v1;
      serve(exp_id, int'($urandom_range(0, 2)), 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Reset while idx==2 discards the operation.
    req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1234; req0_cin = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_add_a", add_a, 4'hB);
    rst = 1'b1;
    #1;
    check_quiet("midrun_reset");
    check("midrun_reset_add_b", add_b, 4'h0);
    check("midrun_reset_ready", {req1_ready, req0_ready}, 2'b00);
    tick();
    rst = 1'b0;
    model_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale_rsp", rsp_valid, 1'b0);
    end
    req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd3; req1_cin = 1'b0;
    serve(1'b1, 0, 1'b0);

    // Sole requester held valid: back-to-back grants every NIBBLES+2 cycles.
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      serve(1'b1, 0, 1'b1);
    end
    req1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
